// File: rtl/dmem_responder.sv
// dmem_responder: word RAM behind a valid/ready port with WAIT_CYCLES wait states; define DMEM_ALIGN_CHECK_EN to reject misaligned addresses
module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic lat_write, lat_mis;
  logic [ADDR_W-1:0] lat_idx;
  logic [31:0] lat_wdata;
  logic [31:0] mem [2**ADDR_W];
  logic accept, access, a_write, a_mis, mis;
  logic [ADDR_W-1:0] a_idx;
  logic [31:0] a_wdata;
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = req_addr[1:0] != 2'b00;
`else
  assign mis = 1'b0;
`endif
  assign accept = state == IDLE && req_valid;
  assign access = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1);
  assign a_write = state == IDLE ? req_write : lat_write;
  assign a_mis = state == IDLE ? mis : lat_mis;
  assign a_idx = state == IDLE ? req_addr[ADDR_W+1:2] : lat_idx;
  assign a_wdata = state == IDLE ? req_wdata : lat_wdata;
  // next state: accept from IDLE, leave WAIT when the counter reaches 1, RESP lasts one cycle
  always_comb
    next = state == IDLE ? (req_valid ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE)
         : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT)
         : IDLE;
  // outputs decoded from registered state only
  always_comb begin
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    busy = state != IDLE;
  end
  // state, request latch, wait counter and response registers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      lat_write <= 1'b0;
      lat_mis <= 1'b0;
      lat_idx <= '0;
      lat_wdata <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        cnt <= 4'(WAIT_CYCLES);
        lat_write <= req_write;
        lat_mis <= mis;
        lat_idx <= req_addr[ADDR_W+1:2];
        lat_wdata <= req_wdata;
      end else if (state == WAIT)
        cnt <= cnt - 4'd1;
      if (access) begin
        resp_err <= a_mis;
        resp_rdata <= a_mis ? 32'h0 : a_write ? a_wdata : mem[a_idx];
      end
    end
  // RAM write port; contents are deliberately not touched by reset
  always_ff @(posedge clock)
    if (access && a_write && !a_mis)
      mem[a_idx] <= a_wdata;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of the default (2 wait state) and zero-wait-state responders
module tb_dmem_responder;
  logic clock = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_valid0 = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic req_ready0, resp_valid0, resp_err0, busy0;
  logic [31:0] resp_rdata0;
  int checks = 0, errors = 0;
  logic [31:0] rd;
  logic er;

  dmem_responder dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready0),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0), .busy(busy0)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one access on dut; hold=1 keeps req_valid high and walks req_addr while waiting
  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic hold,
                     output logic [31:0] rdata, output logic err);
    int lat, nb;
    @(negedge clock);
    chk({tag, "_ready_before"}, req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clock);
    @(negedge clock);
    if (!hold) req_valid = 1'b0;
    lat = 0; nb = 0; rdata = 'x; err = 'x;
    for (int i = 1; i <= 6; i++) begin
      if (hold) req_addr = req_addr + 32'd4;
      if (busy) nb++;
      if (resp_valid) begin
        lat = i; rdata = resp_rdata; err = resp_err;
        break;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_busy_cycles"}, nb, 3);
    @(negedge clock);
    chk({tag, "_resp_drop"}, resp_valid, 0);
    chk({tag, "_ready_back"}, req_ready, 1);
    chk({tag, "_rdata_hold"}, resp_rdata, rdata);
  endtask

  initial begin
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req_ready0, 1);
    @(negedge clock);
    reset = 1'b0;

    txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, er);
    chk("st10_rdata", rd, 32'hDEADBEEF);
    chk("st10_err", er, 0);
    txn("ld10", 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
    chk("ld10_rdata", rd, 32'hDEADBEEF);

    txn("st04", 1'b1, 32'h4, 32'h1234, 1'b0, rd, er);
    txn("ld1004", 1'b0, 32'h1004, 32'h0, 1'b0, rd, er);
    chk("alias_rdata", rd, 32'h1234);

    txn("st20", 1'b1, 32'h20, 32'h5, 1'b0, rd, er);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h99;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk("inflight_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_ready", req_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_rdata", resp_rdata, 0);
    chk("arst_err", resp_err, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    txn("ld20", 1'b0, 32'h20, 32'h0, 1'b0, rd, er);
    chk("dropped_store", rd, 32'h5);

    txn("st22", 1'b1, 32'h22, 32'hFFFF, 1'b0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_err", er, 1);
    chk("mis_rdata", rd, 0);
    txn("ld20b", 1'b0, 32'h20, 32'h0, 1'b0, rd, er);
    chk("mis_nowrite", rd, 32'h5);
`else
    chk("mis_err", er, 0);
    chk("mis_rdata", rd, 32'hFFFF);
    txn("ld20b", 1'b0, 32'h20, 32'h0, 1'b0, rd, er);
    chk("trunc_write", rd, 32'hFFFF);
`endif

    txn("st40", 1'b1, 32'h40, 32'hAAAA, 1'b0, rd, er);
    txn("st44", 1'b1, 32'h44, 32'hBBBB, 1'b0, rd, er);
    txn("hold40", 1'b0, 32'h40, 32'h0, 1'b1, rd, er);
    chk("hold_latched_addr", rd, 32'hAAAA);

    @(negedge clock);
    req_valid0 = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h77;
    @(posedge clock);
    @(negedge clock);
    req_valid0 = 1'b0;
    chk("w0_st_valid", resp_valid0, 1);
    chk("w0_st_busy", busy0, 1);
    chk("w0_st_rdata", resp_rdata0, 32'h77);
    @(negedge clock);
    chk("w0_ready_back", req_ready0, 1);
    req_valid0 = 1'b1; req_write = 1'b0; req_wdata = 32'h0;
    @(posedge clock);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      chk($sformatf("w0_resp_valid_%0d", i), resp_valid0, i % 2);
      chk($sformatf("w0_ready_%0d", i), req_ready0, 1 - i % 2);
      if (i % 2 == 1) chk($sformatf("w0_rdata_%0d", i), resp_rdata0, 32'h77);
    end
    req_valid0 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
